// File: rtl/accum_seq_ctrl.sv
// Sequencing controller for the adder/accumulator datapath: clears/enables the counter,
// steers the output mux and streams the selected bytes over a valid/ready handshake.
module accum_seq_ctrl #(
   parameter int ITER_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              cmd,
   input  logic              clr_first,
   input  logic [ITER_W-1:0] iter,
   input  logic              out_ready,
   output logic [1:0]        mux_sel,
   output logic              out_valid,
   output logic              out_last,
   output logic              counter_en,
   output logic              counter_clr,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] MUX_SEL_REGISTER_2_LSB = 2'd0;
   localparam logic [1:0] MUX_SEL_REGISTER_2_MSB = 2'd1;
   localparam logic [1:0] MUX_SEL_COUNTER_VALUE  = 2'd2;
   localparam logic [1:0] MUX_SEL_COUNTER_CARRY  = 2'd3;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      CLEAR      = 3'd1,
      ACCUM      = 3'd2,
      SEND_LSB   = 3'd3,
      SEND_MSB   = 3'd4,
      SEND_VAL   = 3'd5,
      SEND_CARRY = 3'd6
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [ITER_W-1:0] count;
   logic [ITER_W-1:0] next_count;
   logic              transfer;

   logic [1:0]        next_mux_sel;
   logic              next_out_valid;
   logic              next_out_last;
   logic              next_counter_en;
   logic              next_counter_clr;
   logic              next_busy;
   logic              next_done;

   assign transfer = out_valid & out_ready;

   // Next-state and next-output decode. Outputs are decoded from the next state so that
   // mux_sel is already settled in the same cycle out_valid rises.
   always_comb begin
      next_state       = state;
      next_count       = count;
      next_done        = 1'b0;
      next_mux_sel     = MUX_SEL_REGISTER_2_LSB;
      next_out_valid   = 1'b0;
      next_out_last    = 1'b0;
      next_counter_en  = 1'b0;
      next_counter_clr = 1'b0;
      next_busy        = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               next_count = iter;
               if (!cmd)
                  next_state = SEND_LSB;
               else if (clr_first)
                  next_state = CLEAR;
               else if (iter != '0)
                  next_state = ACCUM;
               else
                  next_state = SEND_VAL;
            end
         end
         CLEAR: begin
            next_state = (count != '0) ? ACCUM : SEND_VAL;
         end
         ACCUM: begin
            // A zero count here is unreachable; treat it like the last cycle anyway.
            next_count = count - ITER_W'(1);
            if (count <= ITER_W'(1))
               next_state = SEND_VAL;
         end
         SEND_LSB: begin
            if (transfer)
               next_state = SEND_MSB;
         end
         SEND_MSB: begin
            if (transfer) begin
               next_state = IDLE;
               next_done  = 1'b1;
            end
         end
         SEND_VAL: begin
            if (transfer)
               next_state = SEND_CARRY;
         end
         SEND_CARRY: begin
            if (transfer) begin
               next_state = IDLE;
               next_done  = 1'b1;
            end
         end
         default: begin
            next_state = IDLE;
            next_count = '0;
         end
      endcase

      next_busy = (next_state != IDLE);
      case (next_state)
         CLEAR:      next_counter_clr = 1'b1;
         ACCUM:      next_counter_en  = 1'b1;
         SEND_LSB: begin
            next_mux_sel   = MUX_SEL_REGISTER_2_LSB;
            next_out_valid = 1'b1;
         end
         SEND_MSB: begin
            next_mux_sel   = MUX_SEL_REGISTER_2_MSB;
            next_out_valid = 1'b1;
            next_out_last  = 1'b1;
         end
         SEND_VAL: begin
            next_mux_sel   = MUX_SEL_COUNTER_VALUE;
            next_out_valid = 1'b1;
         end
         SEND_CARRY: begin
            next_mux_sel   = MUX_SEL_COUNTER_CARRY;
            next_out_valid = 1'b1;
            next_out_last  = 1'b1;
         end
         default: ;
      endcase
   end

   // State, iteration count and registered outputs; reset leaves the datapath counter untouched.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         mux_sel     <= MUX_SEL_REGISTER_2_LSB;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         counter_en  <= 1'b0;
         counter_clr <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= next_state;
         count       <= next_count;
         mux_sel     <= next_mux_sel;
         out_valid   <= next_out_valid;
         out_last    <= next_out_last;
         counter_en  <= next_counter_en;
         counter_clr <= next_counter_clr;
         busy        <= next_busy;
         done        <= next_done;
      end
   end

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Self-checking bench for accum_seq_ctrl: a directed vector table, hand-written corner
// sequences and randomized commands checked against a phase-list model of each command.
module tb_accum_seq_ctrl;

   localparam int ITER_W = 8;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              cmd;
   logic              clr_first;
   logic [ITER_W-1:0] iter;
   logic              out_ready;
   logic [1:0]        mux_sel;
   logic              out_valid;
   logic              out_last;
   logic              counter_en;
   logic              counter_clr;
   logic              busy;
   logic              done;

   int cmp_count  = 0;
   int fail_count = 0;

   accum_seq_ctrl #(.ITER_W(ITER_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cmd        (cmd),
      .clr_first  (clr_first),
      .iter       (iter),
      .out_ready  (out_ready),
      .mux_sel    (mux_sel),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .counter_en (counter_en),
      .counter_clr(counter_clr),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output vector layout: {mux_sel[1:0], out_valid, out_last, counter_en, counter_clr, busy, done}
   function automatic logic [7:0] mk(input logic [1:0] s, input logic v, input logic l,
                                     input logic en, input logic cl, input logic b, input logic d);
      return {s, v, l, en, cl, b, d};
   endfunction

   localparam logic [7:0] IDLE_V  = 8'b00_000000;
   localparam logic [7:0] DONE_V  = 8'b00_000001;
   localparam logic [7:0] CLR_V   = 8'b00_000110;
   localparam logic [7:0] EN_V    = 8'b00_001010;
   localparam logic [7:0] LSB_V   = 8'b00_100010;
   localparam logic [7:0] MSB_V   = 8'b01_110010;
   localparam logic [7:0] VAL_V   = 8'b10_100010;
   localparam logic [7:0] CARRY_V = 8'b11_110010;

   typedef struct {
      logic       rst_n;
      logic       start;
      logic       cmd;
      logic       clr;
      logic [7:0] iter;
      logic       ready;
      logic [7:0] expected;
      string      name;
   } vec_t;

   typedef struct {
      logic [7:0] vec;
      bit         is_byte;
   } phase_t;

   vec_t tbl[15];

   task automatic setRow(input int i, input logic r, input logic s, input logic c, input logic cf,
                         input logic [7:0] it, input logic rd, input logic [7:0] e, input string n);
      tbl[i].rst_n    = r;
      tbl[i].start    = s;
      tbl[i].cmd      = c;
      tbl[i].clr      = cf;
      tbl[i].iter     = it;
      tbl[i].ready    = rd;
      tbl[i].expected = e;
      tbl[i].name     = n;
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic c, input logic cf,
                                input logic [7:0] it, input logic rd);
      rst_n     = r;
      start     = s;
      cmd       = c;
      clr_first = cf;
      iter      = it;
      out_ready = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] expected);
      logic [7:0] actual;
      actual = {mux_sel, out_valid, out_last, counter_en, counter_clr, busy, done};
      cmp_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %b, expected %b (sel,valid,last,en,clr,busy,done)",
                  name, actual, expected);
      end
   endtask

   task automatic checkCount(input string name, input int actual, input int expected);
      cmp_count++;
      if (actual != expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Runs one command. The model expands the command into a list of phases (clear, one per
   // accumulate cycle, one per byte); byte phases advance only on a cycle with out_ready high.
   task automatic runCommand(input logic c, input logic cf, input logic [7:0] it,
                             input int ready_pct, input bit noise, input string tag);
      phase_t ph[$];
      phase_t tmp;
      int     p;
      int     guard;
      int     en_seen;
      int     clr_seen;
      logic   rdy;

      if (c) begin
         if (cf) begin
            tmp.vec = CLR_V; tmp.is_byte = 1'b0; ph.push_back(tmp);
         end
         for (int i = 0; i < int'(it); i++) begin
            tmp.vec = EN_V; tmp.is_byte = 1'b0; ph.push_back(tmp);
         end
         tmp.vec = VAL_V;   tmp.is_byte = 1'b1; ph.push_back(tmp);
         tmp.vec = CARRY_V; tmp.is_byte = 1'b1; ph.push_back(tmp);
      end else begin
         tmp.vec = LSB_V; tmp.is_byte = 1'b1; ph.push_back(tmp);
         tmp.vec = MSB_V; tmp.is_byte = 1'b1; ph.push_back(tmp);
      end

      applyStimulus(1'b1, 1'b1, c, cf, it, 1'b1);
      p        = 0;
      guard    = 0;
      en_seen  = 0;
      clr_seen = 0;
      forever begin
         checkOutput(tag, ph[p].vec);
         en_seen  += int'(counter_en);
         clr_seen += int'(counter_clr);
         rdy       = ($urandom_range(1, 100) <= ready_pct);
         out_ready = rdy;
         if (noise) begin
            start     = 1'($urandom_range(0, 1));
            cmd       = 1'($urandom_range(0, 1));
            clr_first = 1'($urandom_range(0, 1));
            iter      = 8'($urandom_range(0, 255));
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         if (!ph[p].is_byte || rdy)
            p++;
         if (p == ph.size())
            break;
         guard++;
         if (guard > 5000) begin
            cmp_count++;
            fail_count++;
            $display("[TB] FAIL %s_timeout: got no completion after %0d cycles, expected completion", tag, guard);
            start = 1'b0;
            return;
         end
      end
      start = 1'b0;
      checkOutput({tag, "_done"}, DONE_V);
      checkCount({tag, "_en_cycles"}, en_seen, c ? int'(it) : 0);
      checkCount({tag, "_clr_cycles"}, clr_seen, (c && cf) ? 1 : 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: got simulation still running, expected $finish");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      cmd       = 1'b0;
      clr_first = 1'b0;
      iter      = '0;
      out_ready = 1'b0;

      // Reset with start held high, READBACK, ACCUM iter=0, back-to-back start in the done cycle.
      setRow(0,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, IDLE_V,  "reset_0");
      setRow(1,  1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 1'b1, IDLE_V,  "reset_1");
      setRow(2,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, IDLE_V,  "reset_2");
      setRow(3,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, IDLE_V,  "post_reset_idle");
      setRow(4,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, LSB_V,   "rb_lsb");
      setRow(5,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, MSB_V,   "rb_msb");
      setRow(6,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, DONE_V,  "rb_done");
      setRow(7,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, IDLE_V,  "rb_idle");
      setRow(8,  1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, VAL_V,   "iter0_val");
      setRow(9,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, CARRY_V, "iter0_carry");
      setRow(10, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, DONE_V,  "iter0_done");
      setRow(11, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, LSB_V,   "b2b_lsb");
      setRow(12, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, LSB_V,   "b2b_lsb_hold");
      setRow(13, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, MSB_V,   "b2b_msb");
      setRow(14, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, DONE_V,  "b2b_done");

      for (int i = 0; i < 15; i++) begin
         applyStimulus(tbl[i].rst_n, tbl[i].start, tbl[i].cmd, tbl[i].clr, tbl[i].iter, tbl[i].ready);
         checkOutput(tbl[i].name, tbl[i].expected);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      checkOutput("idle_after_table", IDLE_V);

      runCommand(1'b1, 1'b1, 8'd5, 100, 1'b0, "accum_clr5");

      // Backpressure in SEND_VAL with start pulses that must be ignored.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1);
      checkOutput("bp_en1", EN_V);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'd7, 1'b1);
      checkOutput("bp_en2", EN_V);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      checkOutput("bp_val", VAL_V);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, (i % 2) == 0, 1'b0, 1'b0, 8'd0, 1'b0);
         checkOutput("bp_val_hold", VAL_V);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
      checkOutput("bp_carry", CARRY_V);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      checkOutput("bp_done", DONE_V);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      checkOutput("bp_not_queued", IDLE_V);

      // Reset at the third accumulate cycle of iter=10.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd10, 1'b1);
      checkOutput("rst_mid_en1", EN_V);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      checkOutput("rst_mid_en2", EN_V);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      checkOutput("rst_mid_en3", EN_V);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      checkOutput("rst_mid_reset", IDLE_V);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      checkOutput("rst_mid_no_done", IDLE_V);
      runCommand(1'b0, 1'b0, 8'd0, 100, 1'b0, "rst_mid_readback");

      runCommand(1'b1, 1'b0, 8'd255, 100, 1'b0, "accum_max");
      runCommand(1'b1, 1'b1, 8'd0, 50, 1'b1, "accum_clr0");

      for (int n = 0; n < 40; n++) begin
         logic       rc;
         logic       rcf;
         logic [7:0] rit;
         rc  = 1'($urandom_range(0, 1));
         rcf = 1'($urandom_range(0, 1));
         rit = 8'($urandom_range(0, 12));
         runCommand(rc, rcf, rit, 60, 1'b1, "random");
         if ($urandom_range(0, 2) == 0) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'($urandom_range(0, 1)));
            checkOutput("random_gap", IDLE_V);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
      $finish;
   end

endmodule

// File: doc/accum_seq_ctrl.md
Name: accum_seq_ctrl

Overview:
Sequencing controller for the adder/accumulator datapath. It accepts a command, pulses the accumulator counter enable for a programmed number of cycles, and drives the 2-bit output-mux select. It then streams the selected bytes out over a valid/ready handshake. It sits between the host command interface and the mux/counter pair; the mux data output is the byte stream qualified by out_valid.

Parameters:
ITER_W, 8, width of the iteration-count field (maximum of 2^ITER_W-1 accumulate cycles)

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  command strobe; sampled only in IDLE
cmd  input  1  0 = READBACK (stream register_2 LSB then MSB), 1 = ACCUM (accumulate, then stream counter value then carry)
clr_first  input  1  ACCUM only: clear the counter before accumulating
iter  input  ITER_W  ACCUM only: number of counter_en cycles
out_ready  input  1  downstream accepts the current byte
mux_sel  output  2  drives the mux select; uses the MUX_SEL_* encodings
out_valid  output  1  the mux data output holds a valid byte
out_last  output  1  the current byte is the final byte of the command
counter_en  output  1  accumulator count/add enable
counter_clr  output  1  accumulator synchronous clear
busy  output  1  high in every non-IDLE state
done  output  1  one-cycle pulse after the final byte is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous and active-low. It is sampled on the clk rising edge; when low, all state and outputs load their reset values on that edge.
- Reset values: state IDLE, mux_sel = MUX_SEL_REGISTER_2_LSB, out_valid=0, out_last=0, counter_en=0, counter_clr=0, busy=0, done=0, internal iteration count=0.
- All outputs are registered and decoded from the next state, so mux_sel is stable in the same cycle out_valid rises.
- States: IDLE, CLEAR, ACCUM, SEND_LSB, SEND_MSB, SEND_VAL, SEND_CARRY.
- IDLE with start=1 at an edge:
  - cmd, clr_first and iter are latched.
  - cmd=0: go to SEND_LSB.
  - cmd=1, clr_first=1: go to CLEAR.
  - cmd=1, clr_first=0, iter!=0: go to ACCUM.
  - cmd=1, clr_first=0, iter=0: go to SEND_VAL.
- CLEAR: counter_clr=1 for exactly one cycle. Next state is ACCUM, or SEND_VAL if the latched iter=0.
- ACCUM: counter_en=1 for exactly the latched iter consecutive cycles; the down-counter decrements each cycle. When the count reaches 1, go to SEND_VAL.
- counter_en and counter_clr are never both high.
- SEND states drive out_valid=1 and mux_sel:
  - SEND_LSB: MUX_SEL_REGISTER_2_LSB
  - SEND_MSB: MUX_SEL_REGISTER_2_MSB
  - SEND_VAL: MUX_SEL_COUNTER_VALUE
  - SEND_CARRY: MUX_SEL_COUNTER_CARRY
- Handshake:
  - A byte transfers on an edge where out_valid=1 and out_ready=1.
  - Without a transfer, the state, mux_sel and out_valid hold indefinitely (no timeout).
  - out_valid never drops before its transfer.
- Transitions: SEND_LSB→SEND_MSB and SEND_VAL→SEND_CARRY on transfer. out_last=1 in SEND_MSB and SEND_CARRY; a transfer there goes to IDLE with done=1 for one cycle.
- Back-to-back: start is accepted in the cycle done is high, because the state is IDLE.
- Illegal commands: start while busy=1 is ignored and not queued.
- iter is treated as unsigned; there is no wrap hazard because the count is checked for zero at latch time.
- Unused state encodings recover to IDLE with reset output values.
- Reset mid-operation: rst_n=0 at any edge forces IDLE and reset outputs on that edge. counter_en, counter_clr and out_valid drop immediately with no done pulse. The counter contents are not cleared by this block.
- Latency from a start accepted at edge k (out_ready held high):
  - READBACK: valid bytes at cycles k+1 and k+2, done at k+3.
  - ACCUM, iter=N, no clear: counter_en in cycles k+1..k+N, value at k+N+1, carry at k+N+2, done at k+N+3.
  - Clearing adds one cycle.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 → all outputs at reset values, busy=0, mux_sel=LSB; release → still IDLE until start.
- READBACK, out_ready=1: start, cmd=0 → mux_sel LSB then MSB with out_valid in 2 consecutive cycles; out_last only on MSB; done one cycle later.
- ACCUM, clr_first=1, iter=5, out_ready=1 → counter_clr 1 cycle, counter_en exactly 5 cycles, then VALUE/CARRY bytes; 3-in-6-out style counts checked against the datapath model.
- ACCUM iter=0, clr_first=0 → no counter_en, first byte VALUE at k+1.
- Backpressure: out_ready low 4 cycles in SEND_VAL → mux_sel/out_valid stable; start pulses during busy ignored; release → CARRY, then done.
- Reset in ACCUM at cycle 3 of iter=10 → counter_en low next cycle, IDLE, no done; a new READBACK then completes normally.
